// File: rtl/tia_hmove_if.sv
// Bus between an HMOVE/HMxx register front end and the HMOVE motion-clock sequencer.
// The master drives strobes and register writes; the slave returns motion pulses and status.
interface tia_hmove_if #(
    parameter int N_OBJ = 5
);
    logic             hmove;
    logic             hmclr;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [3:0]       wr_data;
    logic             line_rst;
    logic [N_OBJ-1:0] motclk;
    logic             busy;
    logic             ext_hblank;

    modport master (
        output hmove, hmclr, wr_en, wr_addr, wr_data, line_rst,
        input  motclk, busy, ext_hblank
    );

    modport slave (
        input  hmove, hmclr, wr_en, wr_addr, wr_data, line_rst,
        output motclk, busy, ext_hblank
    );
endinterface

// File: rtl/tia_hmove_sequencer.sv
// TIA HMOVE sequencer: HMxx registers, 16-tick extra-clock schedule, extended HBLANK.
// Optional macro TIA_HMOVE_LIVE_COMPARE_EN compares against live HM values instead of a snapshot.
module tia_hmove_sequencer #(
    parameter int PHASE_DIV = 4,
    parameter int N_OBJ     = 5
) (
    input logic        clk,
    input logic        rl,
    tia_hmove_if.slave bus
);
    localparam int              PW      = (PHASE_DIV > 2) ? $clog2(PHASE_DIV) : 1;
    localparam logic [PW-1:0]   PH_LAST = PW'(PHASE_DIV - 1);
    localparam logic [PW-1:0]   PH_PRE  = PW'(PHASE_DIV - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    phase;
    logic [3:0]       tick;
    logic [3:0]       hm    [N_OBJ];
    logic [3:0]       extra [N_OBJ];
    logic [N_OBJ-1:0] hit;
    logic [N_OBJ-1:0] motclk_q;
    logic             ext_q;

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            extra[i] = hm[i] ^ 4'h8;
        end
    end

`ifdef TIA_HMOVE_LIVE_COMPARE_EN
    // Once an object misses a tick it stays stopped for the rest of the run.
    logic [N_OBJ-1:0] alive;

    always_comb begin
        // NOTE: default assignment first, so no path leaves hit holding a value (no latch).
        hit = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            hit[i] = alive[i] && (tick < extra[i]);
        end
    end
`else
    logic [3:0] snap [N_OBJ];

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            hit[i] = tick < snap[i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rl) begin
            // NOTE: the HM file is architectural state, so every entry is reset explicitly.
            for (int i = 0; i < N_OBJ; i++) begin
                hm[i] <= 4'h0;
            end
        end else if (bus.hmclr) begin
            for (int i = 0; i < N_OBJ; i++) begin
                hm[i] <= 4'h0;
            end
        end else if (bus.wr_en) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (bus.wr_addr == 3'(i)) begin
                    hm[i] <= bus.wr_data;
                end
            end
        end
    end

    // motclk is registered one cycle early (at PH_PRE) so it is high while phase == PH_LAST.
    always_ff @(posedge clk) begin
        if (!rl) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state    <= ST_IDLE;
            phase    <= '0;
            tick     <= 4'h0;
            motclk_q <= '0;
            ext_q    <= 1'b0;
`ifdef TIA_HMOVE_LIVE_COMPARE_EN
            alive    <= '0;
`else
            for (int i = 0; i < N_OBJ; i++) begin
                snap[i] <= 4'h0;
            end
`endif
        end else begin
            if (bus.hmove) begin
                ext_q <= 1'b1;
            end else if (bus.line_rst) begin
                ext_q <= 1'b0;
            end

            if (bus.hmove) begin
                state    <= ST_RUN;
                phase    <= '0;
                tick     <= 4'h0;
                motclk_q <= '0;
`ifdef TIA_HMOVE_LIVE_COMPARE_EN
                alive    <= '1;
`else
                for (int i = 0; i < N_OBJ; i++) begin
                    snap[i] <= extra[i];
                end
`endif
            end else if (state == ST_RUN) begin
                phase    <= (phase == PH_LAST) ? '0 : phase + PW'(1);
                motclk_q <= (phase == PH_PRE) ? hit : '0;
`ifdef TIA_HMOVE_LIVE_COMPARE_EN
                if (phase == PH_PRE) begin
                    alive <= alive & hit;
                end
`endif
                if (phase == PH_LAST) begin
                    tick <= tick + 4'd1;
                    if (tick == 4'hF) begin
                        state <= ST_IDLE;
                    end
                end
            end else begin
                motclk_q <= '0;
            end
        end
    end

    assign bus.motclk     = motclk_q;
    assign bus.busy       = (state == ST_RUN);
    assign bus.ext_hblank = ext_q;
endmodule

// File: tb/tb_tia_hmove_sequencer.sv
// Self-checking bench for tia_hmove_sequencer: directed scenarios plus randomized runs
// checked cycle by cycle against a schedule model built from tick/cycle arithmetic.
module tb_tia_hmove_sequencer;
    localparam int PD     = 4;
    localparam int NO     = 5;
    localparam int RUNLEN = 16 * PD;
`ifdef TIA_HMOVE_LIVE_COMPARE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rl;

    tia_hmove_if #(.N_OBJ(NO)) bus ();

    tia_hmove_sequencer #(.PHASE_DIV(PD), .N_OBJ(NO)) dut (
        .clk (clk),
        .rl  (rl),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_hm [NO];
    int r_cnt  [NO];
    int r_last [NO];
    int r_mot_err;
    int r_busy_err;
    int r_first_bad;

    function automatic int extra_of(input logic [3:0] v);
        return int'(v ^ 4'h8);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input bit clr, input bit wr, input logic [2:0] a, input logic [3:0] d);
        if (clr) begin
            for (int i = 0; i < NO; i++) m_hm[i] = 4'h0;
        end else if (wr && int'(a) < NO) begin
            m_hm[int'(a)] = d;
        end
    endtask

    task automatic write_hm(input logic [2:0] a, input logic [3:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        model_write(1'b0, 1'b1, a, d);
    endtask

    task automatic set_all_hm(input logic [3:0] d);
        for (int i = 0; i < NO; i++) write_hm(3'(i), d);
    endtask

    // Strobes hmove in cycle 0 and observes cycles 1..n. Optional same-cycle clr/write at
    // cycle 0, a mid-run write at wr_cyc, hmclr at clr_cyc and a restart at rs_cyc (0 = none).
    // Expected pulses: object i fires in run-relative cycle (t+1)*PD while it has fired on all
    // earlier ticks and t is below its limit (snapshot, or current HM when live compare is on).
    task automatic run_seq(input int n, input bit clr0, input bit wr0, input int wr_cyc,
                           input int clr_cyc, input logic [2:0] wa, input logic [3:0] wd,
                           input int rs_cyc);
        int s;
        int snp [NO];
        bit alv [NO];
        logic [NO-1:0] exp_m;
        logic [NO-1:0] nxt;
        int rel;
        int t;
        int lim;
        bit exp_busy;
        s = 0;
        for (int i = 0; i < NO; i++) begin
            snp[i] = extra_of(m_hm[i]);
            alv[i] = 1'b1;
            r_cnt[i] = 0;
            r_last[i] = 0;
        end
        r_mot_err = 0;
        r_busy_err = 0;
        r_first_bad = -1;
        bus.hmove = 1'b1; bus.hmclr = clr0; bus.wr_en = wr0; bus.wr_addr = wa; bus.wr_data = wd;
        step();
        model_write(clr0, wr0, wa, wd);
        bus.hmove = 1'b0; bus.hmclr = 1'b0; bus.wr_en = 1'b0;
        exp_m = '0;
        for (int c = 1; c <= n; c++) begin
            exp_busy = (c - s >= 1) && (c - s <= RUNLEN);
            if (bus.motclk !== exp_m) begin
                r_mot_err++;
                if (r_first_bad < 0) r_first_bad = c;
            end
            if (bus.busy !== exp_busy) begin
                r_busy_err++;
                if (r_first_bad < 0) r_first_bad = c;
            end
            for (int i = 0; i < NO; i++) begin
                if (bus.motclk[i] === 1'b1) begin
                    r_cnt[i]++;
                    r_last[i] = c;
                end
            end
            if (c == rs_cyc) begin
                bus.hmove = 1'b1;
                s = c;
                for (int i = 0; i < NO; i++) begin
                    snp[i] = extra_of(m_hm[i]);
                    alv[i] = 1'b1;
                end
            end
            rel = c + 1 - s;
            nxt = '0;
            if (rel % PD == 0 && rel / PD >= 1 && rel / PD <= 16) begin
                t = rel / PD - 1;
                for (int i = 0; i < NO; i++) begin
                    lim = LIVE ? extra_of(m_hm[i]) : snp[i];
                    alv[i] = alv[i] && (t < lim);
                    nxt[i] = alv[i];
                end
            end
            if (c == wr_cyc) begin
                bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
            end
            if (c == clr_cyc) bus.hmclr = 1'b1;
            step();
            model_write(c == clr_cyc, c == wr_cyc, wa, wd);
            bus.hmove = 1'b0; bus.hmclr = 1'b0; bus.wr_en = 1'b0;
            exp_m = nxt;
        end
    endtask

    task automatic test_reset();
        rl = 1'b0;
        bus.hmove = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h7;
        bus.hmclr = 1'b0; bus.line_rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (bus.motclk !== 5'b0) begin n_err++; $display("FAIL reset_motclk: got %b want 00000", bus.motclk); end
            n_cmp++;
            if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
            n_cmp++;
            if (bus.ext_hblank !== 1'b0) begin n_err++; $display("FAIL reset_ext_hblank: got %b want 0", bus.ext_hblank); end
        end
        rl = 1'b1; bus.hmove = 1'b0; bus.wr_en = 1'b0;
        for (int i = 0; i < NO; i++) m_hm[i] = 4'h0;
        step();
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== 8) begin n_err++; $display("FAIL reset_readback_cnt[%0d]: got %0d want 8", i, r_cnt[i]); end
        end
    endtask

    task automatic test_default_run();
        bus.line_rst = 1'b1; step(); bus.line_rst = 1'b0;
        n_cmp++;
        if (bus.ext_hblank !== 1'b0) begin n_err++; $display("FAIL default_ext_cleared: got %b want 0", bus.ext_hblank); end
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        n_cmp++;
        if (r_mot_err !== 0) begin n_err++; $display("FAIL default_pattern: errors %0d first cycle %0d want 0", r_mot_err, r_first_bad); end
        n_cmp++;
        if (r_busy_err !== 0) begin n_err++; $display("FAIL default_busy: errors %0d first cycle %0d want 0", r_busy_err, r_first_bad); end
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== 8 || r_last[i] !== 32) begin
                n_err++; $display("FAIL default_cnt[%0d]: got %0d last %0d want 8 last 32", i, r_cnt[i], r_last[i]);
            end
        end
        n_cmp++;
        if (bus.ext_hblank !== 1'b1) begin n_err++; $display("FAIL default_ext_held: got %b want 1", bus.ext_hblank); end
        bus.line_rst = 1'b1; step(); bus.line_rst = 1'b0;
        n_cmp++;
        if (bus.ext_hblank !== 1'b0) begin n_err++; $display("FAIL default_ext_line_rst: got %b want 0", bus.ext_hblank); end
    endtask

    task automatic test_pattern();
        int want [NO] = '{15, 0, 9, 7, 1};
        write_hm(3'd0, 4'h7); write_hm(3'd1, 4'h8); write_hm(3'd2, 4'h1);
        write_hm(3'd3, 4'hF); write_hm(3'd4, 4'h9);
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        n_cmp++;
        if (r_mot_err !== 0) begin n_err++; $display("FAIL pattern_cycles: errors %0d first cycle %0d want 0", r_mot_err, r_first_bad); end
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== want[i]) begin n_err++; $display("FAIL pattern_cnt[%0d]: got %0d want %0d", i, r_cnt[i], want[i]); end
        end
        n_cmp++;
        if (r_last[0] !== 60) begin n_err++; $display("FAIL pattern_p0_last: got %0d want 60", r_last[0]); end
    endtask

    task automatic test_restart();
        set_all_hm(4'h7);
        run_seq(22 + RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 22);
        n_cmp++;
        if (r_mot_err !== 0) begin n_err++; $display("FAIL restart_pattern: errors %0d first cycle %0d want 0", r_mot_err, r_first_bad); end
        n_cmp++;
        if (r_busy_err !== 0) begin n_err++; $display("FAIL restart_busy: errors %0d first cycle %0d want 0", r_busy_err, r_first_bad); end
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== 20 || r_last[i] !== 82) begin
                n_err++; $display("FAIL restart_cnt[%0d]: got %0d last %0d want 20 last 82", i, r_cnt[i], r_last[i]);
            end
        end
    endtask

    task automatic test_write_during_run();
        int want0;
        want0 = LIVE ? 2 : 15;
        set_all_hm(4'h7);
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 10, 0, 3'd0, 4'h8, 0);
        n_cmp++;
        if (r_mot_err !== 0) begin n_err++; $display("FAIL midwrite_pattern: errors %0d first cycle %0d want 0", r_mot_err, r_first_bad); end
        n_cmp++;
        if (r_cnt[0] !== want0) begin n_err++; $display("FAIL midwrite_p0_cnt: got %0d want %0d", r_cnt[0], want0); end
        n_cmp++;
        if (r_cnt[1] !== 15) begin n_err++; $display("FAIL midwrite_p1_cnt: got %0d want 15", r_cnt[1]); end
    endtask

    task automatic test_same_cycle();
        int want1;
        want1 = LIVE ? 8 : 11;
        set_all_hm(4'h3);
        run_seq(RUNLEN + 4, 1'b1, 1'b1, 0, 0, 3'd1, 4'h5, 0);
        n_cmp++;
        if (r_mot_err !== 0) begin n_err++; $display("FAIL samecycle_pattern: errors %0d first cycle %0d want 0", r_mot_err, r_first_bad); end
        n_cmp++;
        if (r_cnt[1] !== want1) begin n_err++; $display("FAIL samecycle_p1_cnt: got %0d want %0d", r_cnt[1], want1); end
        write_hm(3'd6, 4'h7);
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== 8) begin n_err++; $display("FAIL samecycle_cleared_cnt[%0d]: got %0d want 8", i, r_cnt[i]); end
        end
        bus.line_rst = 1'b1; step();
        bus.hmove = 1'b1; step();
        bus.hmove = 1'b0; bus.line_rst = 1'b0;
        n_cmp++;
        if (bus.ext_hblank !== 1'b1) begin n_err++; $display("FAIL set_beats_clear: got %b want 1", bus.ext_hblank); end
        for (int k = 0; k < RUNLEN + 2; k++) step();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ext_hblank !== 1'b1) begin
            n_err++; $display("FAIL post_run_idle: busy %b ext %b want busy 0 ext 1", bus.busy, bus.ext_hblank);
        end
    endtask

    task automatic test_random();
        int wc, cc, rs;
        logic [2:0] a;
        logic [3:0] d;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 3; k++) write_hm(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            wc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0;
            cc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 64)) : 0;
            a = 3'($urandom_range(0, 7));
            d = 4'($urandom_range(0, 15));
            run_seq(rs + RUNLEN + 4, 1'b0, 1'b0, wc, cc, a, d, rs);
            n_cmp++;
            if (r_mot_err !== 0) begin n_err++; $display("FAIL random_pattern[%0d]: errors %0d first cycle %0d want 0", it, r_mot_err, r_first_bad); end
            n_cmp++;
            if (r_busy_err !== 0) begin n_err++; $display("FAIL random_busy[%0d]: errors %0d first cycle %0d want 0", it, r_busy_err, r_first_bad); end
        end
    endtask

    task automatic test_reset_abort();
        set_all_hm(4'h7);
        run_seq(10, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        rl = 1'b0; step(); rl = 1'b1;
        for (int i = 0; i < NO; i++) m_hm[i] = 4'h0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.motclk !== 5'b0 || bus.ext_hblank !== 1'b0) begin
            n_err++; $display("FAIL abort_state: busy %b motclk %b ext %b want 0 00000 0", bus.busy, bus.motclk, bus.ext_hblank);
        end
        run_seq(RUNLEN + 4, 1'b0, 1'b0, 0, 0, 3'd0, 4'h0, 0);
        for (int i = 0; i < NO; i++) begin
            n_cmp++;
            if (r_cnt[i] !== 8) begin n_err++; $display("FAIL abort_readback_cnt[%0d]: got %0d want 8", i, r_cnt[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_pattern();
        test_restart();
        test_write_during_run();
        test_same_cycle();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tia_hmove_sequencer.md
Name: tia_hmove_sequencer

Overview:
- Schedules the extra motion clocks that an HMOVE strobe injects into the five TIA object position counters: P0, P1, M0, M1 and BL.
- Holds the five 4-bit horizontal-motion registers (HMP0..HMBL).
- On HMOVE, runs a 16-tick shared sequence and emits per-object one-cycle motion pulses toward the d1r-based object counters.
- Drives the extended-HBLANK flag.

Parameters:
PHASE_DIV, 4, clk cycles per motion tick; legal range >=2.
N_OBJ, 5, number of objects; fixed at 5, index order P0,P1,M0,M1,BL.

Ports:
clk  input  1  color clock, single clock domain, all logic on posedge
rl  input  1  reset, synchronous, active-low
hmove  input  1  one-cycle HMOVE strobe
hmclr  input  1  one-cycle strobe; clears all HM registers
wr_en  input  1  HM register write strobe
wr_addr  input  3  0..4 select object; 5..7 ignored
wr_data  input  4  HM value, two's complement -8..+7
line_rst  input  1  start-of-line pulse; clears extended HBLANK
motclk  output  5  per-object extra-clock pulse, bit i = object i
busy  output  1  high while the sequence runs
ext_hblank  output  1  extended-HBLANK request

Behaviour:
- Reset (rl=0 at posedge):
  - hm[0..4]=0, snapshot=0.
  - State IDLE; tick and phase counters 0.
  - motclk=0, busy=0, ext_hblank=0.
  - Aborts any run in progress.
  - rl has priority over every other input.
- Register writes:
  - wr_en with wr_addr<5 loads hm[wr_addr] at the edge; addr 5..7 is a no-op.
  - hmclr zeroes all hm; hmclr beats wr_en in the same cycle.
- Extra-clock count per object: extra_i = hm[i] XOR 4'h8, unsigned 0..15.
  - +7 gives 15; 0 gives 8; -1 gives 7; -8 gives 0.
- States: IDLE, RUN.
  - IDLE -> RUN on hmove.
    - Latch snap[i] = extra_i from pre-edge hm values: a write or hmclr in the same cycle is not seen.
    - tick=0, phase=0.
  - RUN:
    - phase increments each cycle, wraps at PHASE_DIV-1.
    - When phase==PHASE_DIV-1: motclk[i]=1 for that single cycle iff tick < snap[i]; then tick increments.
    - After the tick where tick==15: return to IDLE.
  - Timing: count the cycle after hmove is sampled as cycle 1.
    - motclk pulses can occur only in cycles k*PHASE_DIV, k=1..16.
    - busy=1 for cycles 1..16*PHASE_DIV, 0 otherwise.
    - Object i pulses exactly snap[i] times: ticks 1..snap[i].
- hmove while RUN: restart.
  - Re-snapshot, tick=0, phase=0.
  - Pulses already emitted are not undone.
  - No motclk in the restart cycle.
- motclk is registered and always 0 in IDLE. At most one pulse per object per tick.
- ext_hblank: set at the edge sampling hmove, cleared by line_rst.
  - If both in the same cycle, set wins.
  - Independent of RUN completion.
- hm writes during RUN do not affect the current run; see Optional Feature.

Optional Feature:
Macro: TIA_HMOVE_LIVE_COMPARE_EN
- Defined: the per-tick comparison uses live extra_i computed from current hm[i] instead of snap[i].
  - Writes or hmclr during RUN change pulse counts from the next tick onward.
  - Object i pulses at tick t iff it pulsed on every earlier tick of this run AND t < live extra_i. Once stopped, it stays stopped (hardware latch-clear quirk).
- Undefined: snapshot behaviour above; no live path is synthesized.

Test Plan:
1. Hold rl=0 for 2 cycles with hmove=1, wr_en=1 -> motclk=0, busy=0, ext_hblank=0; read-back via a run shows all objects get 8 pulses.
2. PHASE_DIV=4, all hm=0, hmove -> each motclk bit pulses 8 times, at cycles 4,8,...,32; busy high cycles 1..64; ext_hblank=1 until line_rst.
3. hm = P0 7, P1 8, M0 1, M1 F, BL 9; hmove -> pulse counts 15, 0, 9, 7, 1; P0's last pulse at cycle 60.
4. hmove re-strobed at cycle 22 of a run with all hm=7 -> 5 pulses before the restart, then 15 more at restart-relative cycles 4..60; busy stays high continuously.
5. All hm=7, hmove, then at cycle 10 write hm[0]=8 (-8): macro off -> P0 gets 15 pulses. Macro on -> P0 gets 2 pulses (cycles 4 and 8), none afterwards.
6. hmclr, wr_en and hmove asserted in the same cycle with old hm[1]=3 -> P1 gets 11 pulses; after the run, all hm=0; writes to addr 6 change nothing; line_rst and hmove together leave ext_hblank=1.
